// File: rtl/mem_access_unit_if.sv
// Signal bundle between the MEM-stage access unit, the EX/MEM register, the
// MEM/WB register and the data bus.
interface mem_access_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // EX/MEM side
  logic          M_valid_i;
  logic          M_mem_rd_i;
  logic          M_mem_wr_i;
  logic [1:0]    M_size_i;
  logic          M_sign_ext_i;
  logic [AW-1:0] M_addr_i;
  logic [DW-1:0] M_wdata_i;
  // MEM/WB side
  logic [DW-1:0] mem_data_o;
  logic          stall_o;
  logic          misalign_o;
  // Data bus: dbus_req_o rises from a register and stays high, with
  // we/addr/be/wdata frozen, until the bus returns dbus_ack_i for one cycle;
  // dbus_rdata_i is only meaningful in that ack cycle.
  logic          dbus_req_o;
  logic          dbus_we_o;
  logic [AW-1:0] dbus_addr_o;
  logic [3:0]    dbus_be_o;
  logic [DW-1:0] dbus_wdata_o;
  logic [DW-1:0] dbus_rdata_i;
  logic          dbus_ack_i;
  // FSM state for checkers
  logic [1:0]    dbg_state;

  modport master (
    input  M_valid_i, M_mem_rd_i, M_mem_wr_i, M_size_i, M_sign_ext_i,
           M_addr_i, M_wdata_i, dbus_rdata_i, dbus_ack_i,
    output mem_data_o, stall_o, misalign_o, dbus_req_o, dbus_we_o,
           dbus_addr_o, dbus_be_o, dbus_wdata_o, dbg_state
  );

  modport slave (
    output M_valid_i, M_mem_rd_i, M_mem_wr_i, M_size_i, M_sign_ext_i,
           M_addr_i, M_wdata_i, dbus_rdata_i, dbus_ack_i,
    input  mem_data_o, stall_o, misalign_o, dbus_req_o, dbus_we_o,
           dbus_addr_o, dbus_be_o, dbus_wdata_o, dbg_state
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns an EX/MEM access into one req/ack bus
// transaction, formats load data and stalls the pipeline until it completes.
module mem_access_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic               clk,
  input logic               rst,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  logic          req_q, we_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [DW-1:0] wdata_q, mem_data_q;
  logic [1:0]    size_q, off_q;
  logic          sign_q;

  logic          mem_op, misalign, access;
  logic [1:0]    off;
  logic [3:0]    be_next;
  logic [DW-1:0] wdata_next, load_data;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  assign off    = bus.M_addr_i[1:0];
  assign mem_op = bus.M_valid_i & (bus.M_mem_rd_i | bus.M_mem_wr_i);
  assign access = mem_op & ~misalign;

  always_comb begin
    misalign   = 1'b0;
    be_next    = 4'b1111;
    wdata_next = bus.M_wdata_i;
    case (bus.M_size_i)
      2'b00: begin
        be_next    = 4'b0001 << off;
        wdata_next = {4{bus.M_wdata_i[7:0]}};
      end
      2'b01: begin
        misalign   = off[0];
        be_next    = off[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{bus.M_wdata_i[15:0]}};
      end
      default: misalign = |off;
    endcase
  end

  // Load formatting works from the latched size/offset, not the live EX/MEM inputs.
  always_comb begin
    byte_v    = bus.dbus_rdata_i[{off_q, 3'b000} +: 8];
    half_v    = bus.dbus_rdata_i[{off_q[1], 4'b0000} +: 16];
    load_data = bus.dbus_rdata_i;
    case (size_q)
      2'b00:   load_data = {{24{sign_q & byte_v[7]}}, byte_v};
      2'b01:   load_data = {{16{sign_q & half_v[15]}}, half_v};
      default: load_data = bus.dbus_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      mem_data_q <= '0;
      size_q     <= '0;
      off_q      <= '0;
      sign_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_data_q <= '0;
          if (access) begin
            req_q   <= 1'b1;
            we_q    <= bus.M_mem_wr_i;
            addr_q  <= {bus.M_addr_i[AW-1:2], 2'b00};
            be_q    <= be_next;
            wdata_q <= wdata_next;
            size_q  <= bus.M_size_i;
            off_q   <= off;
            sign_q  <= bus.M_sign_ext_i;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (bus.dbus_ack_i) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            mem_data_q <= we_q ? '0 : load_data;
            state      <= DONE;
          end
        end
        DONE: begin
          // One non-stalled cycle with data held, then back to idle output of zero.
          mem_data_q <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_o      = (state == BUSY) | ((state == IDLE) & access);
  assign bus.misalign_o   = mem_op & misalign;
  assign bus.mem_data_o   = mem_data_q;
  assign bus.dbus_req_o   = req_q;
  assign bus.dbus_we_o    = we_q;
  assign bus.dbus_addr_o  = addr_q;
  assign bus.dbus_be_o    = be_q;
  assign bus.dbus_wdata_o = wdata_q;
  assign bus.dbg_state    = state;

endmodule
